// File: rtl/ryg_pkg.sv
// Shared types and constants for the two-road traffic-light monitor.
// Pattern bit order is {R0,Y0,G0,R1,Y1,G1}.
package ryg_pkg;

    typedef enum logic [1:0] {
        PhRoad1Green  = 2'd0,
        PhRoad1Yellow = 2'd1,
        PhRoad0Green  = 2'd2,
        PhRoad0Yellow = 2'd3
    } phase_e;

    typedef enum logic {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } mon_state_e;

    localparam logic [5:0] PatPh0 = 6'b100001;
    localparam logic [5:0] PatPh1 = 6'b100010;
    localparam logic [5:0] PatPh2 = 6'b001100;
    localparam logic [5:0] PatPh3 = 6'b010100;

    localparam int unsigned GreenCycDefault = 6;
    localparam int unsigned YelCycDefault   = 2;

    function automatic phase_e phase_succ(input phase_e ph);
        return phase_e'(ph + 2'd1);
    endfunction

endpackage

// File: rtl/ryg_pattern_decode.sv
// Combinational decode of the six lamp lines into a phase plus legality flags.
// conflict means both roads are one-hot but the pair is not a legal phase.
module ryg_pattern_decode
    import ryg_pkg::*;
(
    input  logic [1:0] R,
    input  logic [1:0] Y,
    input  logic [1:0] G,
    output logic [1:0] phase,
    output logic       legal,
    output logic       onehot_fail,
    output logic       conflict
);

    logic [5:0] pat;

    assign pat = {R[0], Y[0], G[0], R[1], Y[1], G[1]};

    always_comb begin
        legal = 1'b1;
        phase = PhRoad1Green;
        case (pat)
            PatPh0:  phase = PhRoad1Green;
            PatPh1:  phase = PhRoad1Yellow;
            PatPh2:  phase = PhRoad0Green;
            PatPh3:  phase = PhRoad0Yellow;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        onehot_fail = !($onehot({R[0], Y[0], G[0]}) && $onehot({R[1], Y[1], G[1]}));
        conflict    = !onehot_fail && !legal;
    end

endmodule

// File: rtl/ryg_light_monitor.sv
// Passive checker for the traffic-light generator: lamp legality, phase order and dwell time.
// Define RYG_MON_TIMEOUT_EN to build the unlocked-too-long watchdog driving err_timeout.
module ryg_light_monitor
    import ryg_pkg::*;
#(
    parameter int unsigned GREEN_CYC = GreenCycDefault,
    parameter int unsigned YEL_CYC   = YelCycDefault,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       R,
    input  logic [1:0]       Y,
    input  logic [1:0]       G,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err_pattern,
    output logic             err_conflict,
    output logic             err_seq,
    output logic             err_dwell,
    output logic             err_timeout,
    output logic             err_sticky,
    output logic [CNT_W-1:0] period_cnt
);

    localparam logic [3:0] GreenLim = 4'(GREEN_CYC);
    localparam logic [3:0] YelLim   = 4'(YEL_CYC);

    logic [1:0] dec_phase;
    logic       legal, onehot_fail, conflict;

    ryg_pattern_decode u_decode (
        .R           (R),
        .Y           (Y),
        .G           (G),
        .phase       (dec_phase),
        .legal       (legal),
        .onehot_fail (onehot_fail),
        .conflict    (conflict)
    );

    mon_state_e       state_q, state_d;
    phase_e           phase_q, phase_d, ph_in;
    logic [3:0]       dwell_q, dwell_d, lim;
    logic             have_q, have_d;
    logic             pok_q, pok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_pat, e_conf, e_seq, e_dwell, e_to;
    logic [4:0]       pulse_q, pulse_d;
    logic             sticky_q, sticky_d;
    logic             same_ph, succ_ph, lock_evt;

    assign ph_in    = phase_e'(dec_phase);
    assign same_ph  = (ph_in == phase_q);
    assign succ_ph  = (ph_in == phase_succ(phase_q));
    assign lock_evt = legal && (state_q == StUnlocked) && have_q && !same_ph;
    assign lim      = (phase_q == PhRoad1Green || phase_q == PhRoad0Green) ? GreenLim : YelLim;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StUnlocked;
            phase_q  <= PhRoad1Green;
            dwell_q  <= 4'd0;
            have_q   <= 1'b0;
            pok_q    <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 5'd0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            dwell_q  <= dwell_d;
            have_q   <= have_d;
            pok_q    <= pok_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!legal) begin
            state_d = StUnlocked;
        end else if (lock_evt) begin
            state_d = StLocked;
        end
    end

    // pok_q: the period in progress began at phase 0 and has been error-free so far.
    always_comb begin
        phase_d = phase_q;
        dwell_d = dwell_q;
        have_d  = have_q;
        pok_d   = pok_q;
        cnt_d   = cnt_q;
        e_pat   = !legal && onehot_fail;
        e_conf  = !legal && conflict;
        e_seq   = 1'b0;
        e_dwell = 1'b0;
        if (!legal) begin
            dwell_d = 4'd0;
            pok_d   = 1'b0;
        end else if (state_q == StUnlocked) begin
            have_d  = 1'b1;
            phase_d = ph_in;
            if (lock_evt) begin
                dwell_d = 4'd1;
                pok_d   = (ph_in == PhRoad1Green);
            end
        end else if (same_ph) begin
            if (dwell_q != 4'hf) begin
                dwell_d = dwell_q + 4'd1;
            end
            // Flag only the first overrun sample.
            if (dwell_q == lim && dwell_q != 4'hf) begin
                e_dwell = 1'b1;
                pok_d   = 1'b0;
            end
        end else if (succ_ph) begin
            phase_d = ph_in;
            dwell_d = 4'd1;
            e_dwell = (dwell_q != lim);
            if (phase_q == PhRoad0Yellow) begin
                if (pok_q && !e_dwell) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                pok_d = 1'b1;
            end else if (e_dwell) begin
                pok_d = 1'b0;
            end
        end else begin
            e_seq   = 1'b1;
            phase_d = ph_in;
            dwell_d = 4'd1;
            pok_d   = 1'b0;
        end
    end

`ifdef RYG_MON_TIMEOUT_EN
    logic [5:0] to_q, to_d;

    always_comb begin
        to_d = 6'd0;
        e_to = 1'b0;
        if (state_q == StUnlocked && state_d == StUnlocked) begin
            if (to_q == 6'd31) begin
                e_to = 1'b1;
            end else begin
                to_d = to_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_q <= 6'd0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign e_to = 1'b0;
`endif

    always_comb begin
        pulse_d  = {e_to, e_dwell, e_seq, e_conf, e_pat};
        sticky_d = (|pulse_d) || (sticky_q && !clr_err);
    end

    always_comb begin
        locked       = (state_q == StLocked);
        phase        = phase_q;
        err_pattern  = pulse_q[0];
        err_conflict = pulse_q[1];
        err_seq      = pulse_q[2];
        err_dwell    = pulse_q[3];
        err_timeout  = pulse_q[4];
        err_sticky   = sticky_q;
        period_cnt   = cnt_q;
    end

endmodule

// File: doc/ryg_light_monitor.md
Name: ryg_light_monitor

Overview:
- Passive checker on the lamp outputs of the two-road traffic-light generator.
- Decodes the 6 lamp lines into a phase, locks onto the sequence, and checks three things: lamp legality, phase order and per-phase dwell time.
- Reports single-cycle error pulses, a sticky error flag and a count of completed periods.
- Instantiated beside the generator in system testbenches, and on-chip as a safety watchdog.

Parameters:
- GREEN_CYC, 6, required cycles a road shows green per phase
- YEL_CYC, 2, required cycles a road shows yellow per phase
- CNT_W, 8, width of the completed-period counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- R  in  2  red lamps; bit0 = road0, bit1 = road1
- Y  in  2  yellow lamps, same bit order
- G  in  2  green lamps, same bit order
- clr_err  in  1  synchronous clear of err_sticky
- phase  out  2  decoded phase: 0 road1 green, 1 road1 yellow, 2 road0 green, 3 road0 yellow
- locked  out  1  monitor is tracking the sequence
- err_pattern  out  1  pulse: a road does not have exactly one lamp lit
- err_conflict  out  1  pulse: both roads one-hot but pattern is not one of the 4 legal ones
- err_seq  out  1  pulse: phase changed to a non-successor
- err_dwell  out  1  pulse: phase dwell too long or too short
- err_timeout  out  1  pulse: see Optional Feature
- err_sticky  out  1  OR of all error pulses since reset or clr_err
- period_cnt  out  CNT_W  number of completed correct periods, wraps

Behaviour:
- Legal patterns, bit order {R0,Y0,G0,R1,Y1,G1}:
  - 100001 = phase 0
  - 100010 = phase 1
  - 001100 = phase 2
  - 010100 = phase 3
- Successor order: 0→1→2→3→0.
- Sampling and timing:
  - Inputs are sampled every posedge.
  - All outputs are registered, so a flag reflects the sample taken at the previous edge (1-cycle latency).
- Reset: all outputs are 0, the FSM is in UNLOCKED, and dwell is 0.
- Reset is asynchronous: outputs clear immediately, mid-operation included.
- Internal state: FSM state, last phase, dwell counter (4 bits, saturating at 15).
- FSM UNLOCKED (locked=0):
  - Track the phase while the pattern is legal.
  - On the first change from one legal phase to a different legal phase: go to LOCKED, dwell=1.
  - No dwell or sequence errors are raised in UNLOCKED.
- FSM LOCKED (locked=1), per sample:
  - Illegal pattern: raise err_pattern or err_conflict, go to UNLOCKED, dwell=0.
  - Same phase: dwell+1.
    - If the new dwell exceeds the limit (GREEN_CYC for phases 0/2, YEL_CYC for 1/3), pulse err_dwell once, at the first overrun sample only.
  - Successor phase:
    - If dwell ≠ limit of the old phase, pulse err_dwell.
    - Set dwell=1.
    - On a 3→0 transition with no error during the period, increment period_cnt.
  - Non-successor legal phase: pulse err_seq, set dwell=1, stay LOCKED on the new phase.
- Illegal pattern in UNLOCKED still pulses err_pattern or err_conflict.
- err_pattern has priority over err_conflict; exactly one of the two is raised per illegal sample.
- err_sticky:
  - Set by any error pulse.
  - Cleared by clr_err.
  - If clr_err and an error pulse occur in the same cycle, the error wins and sticky stays 1.
- phase holds its last legal value while the pattern is illegal.
- period_cnt wraps from all-ones to 0 without a flag.

Optional Feature:
- Macro: RYG_MON_TIMEOUT_EN.
- When defined:
  - A 6-bit counter runs while UNLOCKED.
  - If no lock occurs within 32 consecutive UNLOCKED samples, err_timeout pulses and the counter restarts.
  - Entering LOCKED, or reset, zeroes the counter.
- When undefined: err_timeout is tied to 0 and no counter is built.

Decomposition:
- Package ryg_pkg:
  - phase_e enum (4 values)
  - 6-bit legal pattern constants
  - default GREEN_CYC/YEL_CYC constants
  - monitor FSM state enum {UNLOCKED, LOCKED}
- Sub-module ryg_pattern_decode: purely combinational; R/Y/G → phase, legal, onehot_fail, conflict.

Test Plan:
- Drive the generator's 16-cycle sequence after reset → locked rises 1 cycle after the first 0→1 transition sample; no error pulses; period_cnt=5 after 5 further full periods.
- Hold phase 2 (001100) for 7 samples → err_dwell pulses once, on the 7th sample; err_sticky=1; clr_err → err_sticky=0.
- Hold phase 1 for only 1 sample, then phase 2 → err_dwell at the transition; period_cnt does not increment at the next 3→0.
- Inject 101001 for 1 sample while locked → err_pattern=1, locked=0; relocks on the next legal phase change. Inject 001001 → err_conflict=1.
- Jump 100001→001100 while locked → err_seq=1, locked stays 1, phase=2.
- Assert reset asynchronously mid-period with no clock edge → all outputs 0 immediately. With RYG_MON_TIMEOUT_EN, drive a constant 100001 → err_timeout pulses after 32 samples.
